// File: rtl/sar_search.sv
// Successive-approximation search controller: drives a trial value into an external
// comparator and binary-searches MSB-first. Optional early exit: SAR_EARLY_EXIT_EN.
module sar_search #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             found_reg, found_next;
  logic             err_reg, err_next;

  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] trial_val;
  logic [WIDTH-1:0] acc_upd;
  logic             one_hot;
  logic             eq_hit;

  // Decode the bit index into a one-hot mask for the bit under test.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
    assign bit_mask[gi] = (idx_reg == IW'(gi));
  end

  assign trial_val = acc_reg | bit_mask;
  // Exactly one of three: odd parity excludes 0 and 2, the AND term excludes 3.
  assign one_hot   = (cmp_eq ^ cmp_gt ^ cmp_lt) & ~(cmp_eq & cmp_gt & cmp_lt);
  assign eq_hit    = one_hot & cmp_eq;
  assign acc_upd   = (one_hot && (cmp_gt || cmp_eq)) ? trial_val : acc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      idx_reg    <= '0;
      result_reg <= '0;
      found_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      idx_reg    <= idx_next;
      result_reg <= result_next;
      found_reg  <= found_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    idx_next    = idx_reg;
    result_next = result_reg;
    found_next  = found_reg;
    err_next    = err_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          acc_next   = '0;
          idx_next   = IDX_MSB;
          found_next = 1'b0;
          err_next   = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        acc_next = acc_upd;
        if (!one_hot) err_next = 1'b1;
        if (eq_hit) found_next = 1'b1;
        if (EARLY_EXIT && eq_hit) begin
          result_next = trial_val;
          state_next  = DONE;
        end else if (idx_reg == '0) begin
          result_next = acc_upd;
          state_next  = DONE;
        end else begin
          idx_next = idx_reg - IDX_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign trial  = (state_reg == RUN) ? trial_val : '0;
  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign found  = found_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_sar_search.sv
// Randomized bench for sar_search: an ideal (optionally faulty) comparator plus an
// arithmetic model of the expected trial sequence, latency and result.
module tb_sar_search;

  localparam int W = 8;

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cmp_eq, cmp_gt, cmp_lt;
  logic [W-1:0] trial, result;
  logic         busy, done, found, err;

  int n_cmp = 0;
  int n_bad = 0;
  int target = 0;
  bit inject_bad = 1'b0;
  int last_result = 0;

  sar_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_eq (cmp_eq),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .err    (err)
  );

  always #5 clk = ~clk;

  // External comparator; optionally reports gt and lt together on the MSB trial.
  always @* begin
    cmp_eq = (int'(trial) == target);
    cmp_gt = (target > int'(trial));
    cmp_lt = (target < int'(trial));
    if (inject_bad && int'(trial) == (1 << (W - 1))) begin
      cmp_eq = 1'b0;
      cmp_gt = 1'b1;
      cmp_lt = 1'b1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_result = 0;
  endtask

  task automatic run_search(input int tgt, input bit bad, input bit poke_start, input bit hold_start);
    int exp_trial[W];
    int n;
    n = W;
    target = tgt;
    inject_bad = bad;
    // Binary search: step k keeps the top k bits of the target and tests the next one.
    for (int k = 0; k < W; k++) begin
      exp_trial[k] = ((tgt >> (W - k)) << (W - k)) | (1 << (W - 1 - k));
      if (EARLY && exp_trial[k] == tgt && n == W) n = k + 1;
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    for (int k = 0; k < n; k++) begin
      check("trial", int'(trial), exp_trial[k]);
      check("busy_run", int'(busy), 1);
      if (k == 0) begin
        check("done_run", int'(done), 0);
        check("result_hold", int'(result), last_result);
        check("found_cleared", int'(found), 0);
        check("err_cleared", int'(err), 0);
      end
      if (poke_start && k == 3) start = 1'b1;
      else if (!hold_start) start = 1'b0;
      @(posedge clk);
      #1;
    end
    if (!hold_start) start = 1'b0;
    check("done_pulse", int'(done), 1);
    check("busy_done", int'(busy), 0);
    check("trial_done", int'(trial), 0);
    check("result", int'(result), tgt);
    check("found", int'(found), (tgt != 0) ? 1 : 0);
    check("err", int'(err), bad ? 1 : 0);
    last_result = tgt;
    $display("search target=%0d bad=%0d poke=%0d hold=%0d run_cycles=%0d result=%0d found=%0d err=%0d",
             tgt, bad, poke_start, hold_start, n, result, found, err);
    @(posedge clk);
    #1;
    if (hold_start) begin
      check("restart_busy", int'(busy), 1);
      check("restart_done", int'(done), 0);
      check("restart_trial", int'(trial), 1 << (W - 1));
      check("restart_err", int'(err), 0);
      start = 1'b0;
      reset_dut();
    end else begin
      check("idle_done", int'(done), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_err_sticky", int'(err), bad ? 1 : 0);
      check("idle_result", int'(result), tgt);
    end
  endtask

  task automatic reset_mid_run(input int tgt);
    target = tgt;
    inject_bad = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("mid_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("rst_trial", int'(trial), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_found", int'(found), 0);
    check("rst_err", int'(err), 0);
    // start together with rst must not launch a search.
    start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wins_busy", int'(busy), 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_result = 0;
    @(posedge clk);
    #1;
    check("post_rst_idle", int'(busy), 0);
    $display("reset mid-run target=%0d", tgt);
  endtask

  initial begin
    int tgt;
    bit bad;
    repeat (2) @(posedge clk);
    #1;
    check("reset_trial", int'(trial), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);
    check("reset_found", int'(found), 0);
    check("reset_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;

    run_search(100, 1'b0, 1'b0, 1'b0);
    run_search(0,   1'b0, 1'b0, 1'b0);
    run_search(255, 1'b0, 1'b0, 1'b0);
    run_search(100, 1'b0, 1'b1, 1'b0);
    run_search(int'($urandom_range(1, 127)), 1'b1, 1'b0, 1'b0);
    run_search(int'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    run_search(37,  1'b0, 1'b0, 1'b1);
    reset_mid_run(200);

    for (int i = 0; i < 24; i++) begin
      tgt = int'($urandom_range(0, 255));
      bad = (tgt < 128) && ($urandom_range(0, 3) == 0);
      run_search(tgt, bad, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
